// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Default 640x480 @ 60 Hz VGA timing constants (display, porches, sync)
//   plus derived totals and sync-window bounds. Shared by vga_sync_gen and
//   by the object renderers for on-screen placement limits.
//   in_window(): half-open range test lo <= pos < hi on a 10-bit coordinate.
package vga_timing_pkg;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned HSYNC_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HSYNC_END   = HSYNC_START + H_SYNC;
    localparam int unsigned VSYNC_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VSYNC_END   = VSYNC_START + V_SYNC;

    function automatic logic in_window(input logic [9:0] pos,
                                       input int unsigned lo,
                                       input int unsigned hi);
        int unsigned p;
        p = {22'd0, pos};
        return (p >= lo) && (p < hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_mod_counter.sv
// mod_counter
//   Modulo-MODULUS up-counter that advances when enable is high.
//   Resets (asynchronously, active-low) to MODULUS-1 so that the first
//   enabled step lands on 0.
//   Ports: clk, rst_n, enable (advance strobe), count (current value),
//          carry (enable & count == MODULUS-1, i.e. wraps this edge).
module mod_counter #(
    parameter int unsigned MODULUS = 800,
    parameter int unsigned WIDTH   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             carry
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    assign carry = enable && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LAST;
        end else if (enable) begin
            count <= carry ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   Free-running VGA timing generator. Divides clk by CLK_DIV into a pixel
//   strobe, runs horizontal/vertical pixel counters and produces registered
//   active-low HSync/VSync and the video_on qualifier.
//   Ports: clk, rst_n (async active-low), HCount/VCount (pixel coordinates),
//          HSync/VSync (active low), video_on (visible area),
//          pixel_tick (one clk per pixel), frame_tick (last pixel of frame).
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
    parameter int unsigned V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] HCount,
    output logic [9:0] VCount,
    output logic       HSync,
    output logic       VSync,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       frame_tick
);

    import vga_timing_pkg::*;

    localparam int unsigned H_TOT    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOT    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             h_carry;
    logic             v_carry;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;

    // Pixel-rate divider
    assign pixel_tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (pixel_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    mod_counter #(
        .MODULUS (H_TOT),
        .WIDTH   (10)
    ) u_h_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (pixel_tick),
        .count  (HCount),
        .carry  (h_carry)
    );

    mod_counter #(
        .MODULUS (V_TOT),
        .WIDTH   (10)
    ) u_v_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (h_carry),
        .count  (VCount),
        .carry  (v_carry)
    );

    // v_carry already includes pixel_tick and HCount == last column
    assign frame_tick = v_carry;

    // Mirror of the counters' next state; decoding the sync/blank registers
    // from it keeps them aligned with the coordinates they describe.
    always_comb begin
        h_nxt = HCount;
        v_nxt = VCount;
        if (pixel_tick) begin
            h_nxt = h_carry ? '0 : HCount + 10'd1;
        end
        if (h_carry) begin
            v_nxt = v_carry ? '0 : VCount + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            HSync    <= 1'b1;
            VSync    <= 1'b1;
            video_on <= 1'b0;
        end else begin
            HSync    <= !in_window(h_nxt, HS_START, HS_END);
            VSync    <= !in_window(v_nxt, VS_START, VS_END);
            video_on <= in_window(h_nxt, 0, H_DISPLAY) &&
                        in_window(v_nxt, 0, V_DISPLAY);
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
//   Directed self-checking bench for vga_sync_gen. Default-timing instance
//   covers reset, first pixel, tick cadence, line length and HSync placement.
//   Two reduced-timing instances (15x13 total, CLK_DIV 2 and 4) cover the
//   whole-frame behaviour, mid-sync reset and the CLK_DIV override.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // default-timing instance
    logic       d_rst_n = 1'b0;
    logic [9:0] d_h, d_v;
    logic       d_hs, d_vs, d_vo, d_pt, d_ft;

    vga_sync_gen dut (
        .clk        (clk),
        .rst_n      (d_rst_n),
        .HCount     (d_h),
        .VCount     (d_v),
        .HSync      (d_hs),
        .VSync      (d_vs),
        .video_on   (d_vo),
        .pixel_tick (d_pt),
        .frame_tick (d_ft)
    );

    // reduced timing: H 8/2/3/2 (total 15, sync 10..12), V 6/2/2/3 (total 13, sync 8..9)
    logic       s_rst_n = 1'b0;
    logic [9:0] s_h, s_v;
    logic       s_hs, s_vs, s_vo, s_pt, s_ft;

    vga_sync_gen #(
        .CLK_DIV (2),
        .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_DISPLAY (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
    ) dut_s (
        .clk        (clk),
        .rst_n      (s_rst_n),
        .HCount     (s_h),
        .VCount     (s_v),
        .HSync      (s_hs),
        .VSync      (s_vs),
        .video_on   (s_vo),
        .pixel_tick (s_pt),
        .frame_tick (s_ft)
    );

    logic       q_rst_n = 1'b0;
    logic [9:0] q_h, q_v;
    logic       q_hs, q_vs, q_vo, q_pt, q_ft;

    vga_sync_gen #(
        .CLK_DIV (4),
        .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_DISPLAY (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
    ) dut_q (
        .clk        (clk),
        .rst_n      (q_rst_n),
        .HCount     (q_h),
        .VCount     (q_v),
        .HSync      (q_hs),
        .VSync      (q_vs),
        .video_on   (q_vo),
        .pixel_tick (q_pt),
        .frame_tick (q_ft)
    );

    initial begin
        int ticks, alt_err, hold_err, wraps, vincs, found;
        int hs_low, hs_err, vo_err, hs655, hs752, n;
        int ft_cnt, vs_low, vs_err, vo_ticks, run, run_err;
        logic       prev_pt;
        logic [9:0] prev_h, prev_v;

        // ---------------- reset and first pixel (default) ----------------
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_h", int'(d_h), 799);
        chk("rst_v", int'(d_v), 524);
        chk("rst_hs", int'(d_hs), 1);
        chk("rst_vs", int'(d_vs), 1);
        chk("rst_vo", int'(d_vo), 0);
        chk("rst_pt", int'(d_pt), 0);
        chk("rst_ft", int'(d_ft), 0);
        d_rst_n = 1'b1;
        @(negedge clk);
        chk("c1_pt", int'(d_pt), 1);
        chk("c1_ft", int'(d_ft), 1);
        chk("c1_h", int'(d_h), 799);
        chk("c1_v", int'(d_v), 524);
        chk("c1_vo", int'(d_vo), 0);
        @(negedge clk);
        chk("c2_h", int'(d_h), 0);
        chk("c2_v", int'(d_v), 0);
        chk("c2_vo", int'(d_vo), 1);
        chk("c2_pt", int'(d_pt), 0);

        // ---------------- tick cadence and line length ----------------
        ticks = 0; alt_err = 0; hold_err = 0; wraps = 0; vincs = 0;
        prev_pt = d_pt; prev_h = d_h; prev_v = d_v;
        for (int i = 0; i < 3200; i++) begin
            @(negedge clk);
            if (d_pt) ticks++;
            if (d_pt == prev_pt) alt_err++;
            if (d_h != prev_h && !prev_pt) hold_err++;
            if (prev_h == 10'd799 && d_h == 10'd0) wraps++;
            if (d_v == prev_v + 10'd1) vincs++;
            prev_pt = d_pt; prev_h = d_h; prev_v = d_v;
        end
        chk("tick_count", ticks, 1600);
        chk("tick_alternate", alt_err, 0);
        chk("coord_hold", hold_err, 0);
        chk("h_wraps", wraps, 2);
        chk("v_incs", vincs, 2);
        chk("line2_h", int'(d_h), 0);
        chk("line2_v", int'(d_v), 2);

        // ---------------- HSync placement on line 10 ----------------
        for (int i = 0; i < 20000 && !(d_v == 10'd10 && d_h == 10'd0); i++)
            @(negedge clk);
        found = (d_v == 10'd10 && d_h == 10'd0) ? 1 : 0;
        chk("line10_reached", found, 1);
        hs_low = 0; hs_err = 0; vo_err = 0; hs655 = -1; hs752 = -1; n = 0;
        while (d_v == 10'd10 && n < 1700) begin
            if (!d_hs) hs_low++;
            if (int'(d_hs) != ((d_h >= 10'd656 && d_h < 10'd752) ? 0 : 1)) hs_err++;
            if (int'(d_vo) != ((d_h < 10'd640) ? 1 : 0)) vo_err++;
            if (d_h == 10'd655) hs655 = int'(d_hs);
            if (d_h == 10'd752) hs752 = int'(d_hs);
            n++;
            @(negedge clk);
        end
        chk("line10_clks", n, 1600);
        chk("hs_low_clks", hs_low, 192);
        chk("hs_decode", hs_err, 0);
        chk("hs_at_655", hs655, 1);
        chk("hs_at_752", hs752, 1);
        chk("vo_line10", vo_err, 0);

        // ---------------- full frame (reduced timing) ----------------
        s_rst_n = 1'b1;
        @(negedge clk);
        chk("s_c1_ft", int'(s_ft), 1);
        @(negedge clk);
        chk("s_start_h", int'(s_h), 0);
        chk("s_start_v", int'(s_v), 0);
        ft_cnt = 0; vs_low = 0; vs_err = 0; vo_ticks = 0; hs_err = 0;
        for (int i = 0; i < 390; i++) begin
            @(negedge clk);
            if (s_ft) ft_cnt++;
            if (!s_vs) vs_low++;
            if (int'(s_vs) != ((s_v >= 10'd8 && s_v < 10'd10) ? 0 : 1)) vs_err++;
            if (int'(s_hs) != ((s_h >= 10'd10 && s_h < 10'd13) ? 0 : 1)) hs_err++;
            if (s_vo && s_pt) vo_ticks++;
        end
        chk("s_frame_ticks", ft_cnt, 1);
        chk("s_vs_low_clks", vs_low, 60);
        chk("s_vs_decode", vs_err, 0);
        chk("s_hs_decode", hs_err, 0);
        chk("s_vo_ticks", vo_ticks, 48);
        chk("s_end_h", int'(s_h), 0);
        chk("s_end_v", int'(s_v), 0);

        // ---------------- reset during both sync pulses ----------------
        for (int i = 0; i < 1000 && !(s_h == 10'd11 && s_v == 10'd8); i++)
            @(negedge clk);
        found = (s_h == 10'd11 && s_v == 10'd8) ? 1 : 0;
        chk("s_midsync_reached", found, 1);
        chk("s_midsync_hs", int'(s_hs), 0);
        chk("s_midsync_vs", int'(s_vs), 0);
        s_rst_n = 1'b0;
        #1;
        chk("s_async_hs", int'(s_hs), 1);
        chk("s_async_vs", int'(s_vs), 1);
        chk("s_async_h", int'(s_h), 14);
        chk("s_async_v", int'(s_v), 12);
        chk("s_async_pt", int'(s_pt), 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        s_rst_n = 1'b1;
        @(negedge clk);
        chk("s_re_c1_pt", int'(s_pt), 1);
        chk("s_re_c1_ft", int'(s_ft), 1);
        chk("s_re_c1_vo", int'(s_vo), 0);
        @(negedge clk);
        chk("s_re_c2_h", int'(s_h), 0);
        chk("s_re_c2_v", int'(s_v), 0);
        chk("s_re_c2_vo", int'(s_vo), 1);

        // ---------------- CLK_DIV = 4 override ----------------
        q_rst_n = 1'b1;
        @(negedge clk);
        chk("q_c1_pt", int'(q_pt), 0);
        @(negedge clk);
        chk("q_c2_pt", int'(q_pt), 0);
        @(negedge clk);
        chk("q_c3_pt", int'(q_pt), 1);
        chk("q_c3_ft", int'(q_ft), 1);
        @(negedge clk);
        chk("q_start_h", int'(q_h), 0);
        ft_cnt = 0; run = 1; run_err = 0; prev_h = q_h;
        for (int i = 0; i < 780; i++) begin
            @(negedge clk);
            if (q_ft) ft_cnt++;
            if (q_h != prev_h) begin
                if (run != 4) run_err++;
                run = 1;
            end else begin
                run++;
            end
            prev_h = q_h;
        end
        chk("q_hold4", run_err, 0);
        chk("q_frame_ticks", ft_cnt, 1);
        chk("q_end_h", int'(q_h), 0);
        chk("q_end_v", int'(q_v), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
